// File: rtl/mbl_pkg.sv
// Shared state encoding, request record and default widths for the mbl message initiator.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package mbl_pkg;

  localparam int MBL_DATA_W = 32;
  localparam int MBL_TAG_W  = 4;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } mbl_state_e;

  typedef struct packed {
    logic [MBL_TAG_W-1:0]  tag;
    logic [MBL_DATA_W-1:0] data;
  } mbl_req_t;

endpackage

// File: rtl/mbl_tag_tracker.sv
// Tag allocation, expected-response tag and in-flight count for the mbl initiator.
// Latency: counters update on the clock edge of the handshake; resp_err is combinational.
// Backpressure: none of its own; the parent gates allocation with the outst value.
module mbl_tag_tracker
  import mbl_pkg::*;
#(
  parameter int TAG_W     = MBL_TAG_W,
  parameter int MAX_OUTST = 8,
  parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc,
  input  logic             req_fire,
  input  logic             resp_fire,
  input  logic [TAG_W-1:0] resp_tag,
  output logic [TAG_W-1:0] alloc_tag,
  output logic [CNT_W-1:0] outst,
  output logic             resp_err
);

  logic [TAG_W-1:0] tag_cnt_q;
  logic [TAG_W-1:0] exp_tag_q;
  logic [CNT_W-1:0] outst_q;
  logic             none_outst;
  logic             resp_counted;

  assign none_outst   = (outst_q == '0);
  // A response with nothing in flight is flagged but must not disturb the tag or the count.
  assign resp_counted = resp_fire & ~none_outst;

  always_ff @(posedge clk) begin
    if (reset) begin
      tag_cnt_q <= '0;
      exp_tag_q <= '0;
      outst_q   <= '0;
    end else begin
      if (alloc) begin
        tag_cnt_q <= tag_cnt_q + TAG_W'(1);
      end
      if (resp_counted) begin
        exp_tag_q <= exp_tag_q + TAG_W'(1);
      end
      if (req_fire && !resp_counted) begin
        outst_q <= outst_q + CNT_W'(1);
      end else if (!req_fire && resp_counted) begin
        outst_q <= outst_q - CNT_W'(1);
      end
    end
  end

  assign alloc_tag = tag_cnt_q;
  assign outst     = outst_q;
  assign resp_err  = none_outst | (resp_tag != exp_tag_q);

endmodule

// File: rtl/mbl_msg_initiator.sv
// Requester end of the mbl message protocol; response watchdog built only with MBL_INIT_TIMEOUT_EN.
// Latency: one cycle from cmd handshake to msg_req_valid; responses pass to the client combinationally.
// Backpressure: cmd_ready drops when halted, when the in-flight window is full or while the request stalls.
module mbl_msg_initiator
  import mbl_pkg::*;
#(
  parameter int DATA_W      = MBL_DATA_W,
  parameter int TAG_W       = MBL_TAG_W,
  parameter int MAX_OUTST   = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              msg_req_valid,
  input  logic              msg_req_ready,
  output logic [DATA_W-1:0] msg_req_data,
  output logic [TAG_W-1:0]  msg_req_tag,
  input  logic              msg_resp_valid,
  output logic              msg_resp_ready,
  input  logic [DATA_W-1:0] msg_resp_data,
  input  logic [TAG_W-1:0]  msg_resp_tag,
  output logic              msg_busy,
  output logic              halted,
  input  logic              err_clr,
  output logic              timeout_err
);

  localparam int CNT_W = $clog2(MAX_OUTST + 1);

  mbl_state_e        state_q;
  mbl_state_e        state_d;
  logic              req_vld_q;
  logic [DATA_W-1:0] req_data_q;
  logic [TAG_W-1:0]  req_tag_q;
  logic              cmd_fire;
  logic              req_fire;
  logic              resp_fire;
  logic [TAG_W-1:0]  alloc_tag;
  logic [CNT_W-1:0]  outst;
  logic              tag_err;
  logic [CNT_W:0]    inflight;
  logic              room;
  logic              err_evt;
  logic              wd_expire;

  assign cmd_fire  = cmd_valid & cmd_ready;
  assign req_fire  = req_vld_q & msg_req_ready;
  assign resp_fire = msg_resp_valid & msg_resp_ready;

  mbl_tag_tracker #(
    .TAG_W     (TAG_W),
    .MAX_OUTST (MAX_OUTST),
    .CNT_W     (CNT_W)
  ) u_tag_tracker (
    .clk       (clk),
    .reset     (reset),
    .alloc     (cmd_fire),
    .req_fire  (req_fire),
    .resp_fire (resp_fire),
    .resp_tag  (msg_resp_tag),
    .alloc_tag (alloc_tag),
    .outst     (outst),
    .resp_err  (tag_err)
  );

  // The registered-but-unsent request already holds a tag, so it counts against the window.
  assign inflight  = {1'b0, outst} + {{CNT_W{1'b0}}, req_vld_q};
  assign room      = inflight < (CNT_W + 1)'(MAX_OUTST);
  assign cmd_ready = (state_q == RUN) & room & (~req_vld_q | msg_req_ready);

  always_ff @(posedge clk) begin
    if (reset) begin
      req_vld_q <= 1'b0;
    end else if (cmd_fire) begin
      req_vld_q <= 1'b1;
    end else if (msg_req_ready) begin
      req_vld_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_fire) begin
      req_data_q <= cmd_data;
      req_tag_q  <= alloc_tag;
    end
  end

  assign msg_req_valid  = req_vld_q;
  assign msg_req_data   = req_data_q;
  assign msg_req_tag    = req_tag_q;

  assign msg_resp_ready = rsp_ready;
  assign rsp_valid      = msg_resp_valid;
  assign rsp_data       = msg_resp_data;
  assign rsp_err        = msg_resp_valid & tag_err;

  assign err_evt = (resp_fire & tag_err) | wd_expire;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (err_evt) state_d = HALT;
      HALT:    if (err_clr && !err_evt) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  assign halted   = (state_q == HALT);
  assign msg_busy = req_vld_q | (outst != '0);

`ifdef MBL_INIT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

  logic [WD_W-1:0] wd_cnt_q;
  logic            wd_hit;
  logic            wd_idle;
  logic            to_q;
  logic            clr_evt;

  assign wd_hit    = (wd_cnt_q == WD_W'(TIMEOUT_CYC - 1));
  assign wd_idle   = (outst == '0) | resp_fire;
  assign clr_evt   = halted & err_clr;
  // Only the first expiry raises an event, otherwise a stuck count would block err_clr.
  assign wd_expire = ~wd_idle & wd_hit & ~to_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      if (wd_idle || clr_evt) begin
        wd_cnt_q <= '0;
      end else if (!wd_hit) begin
        wd_cnt_q <= wd_cnt_q + WD_W'(1);
      end
      if (wd_expire) begin
        to_q <= 1'b1;
      end else if (clr_evt) begin
        to_q <= 1'b0;
      end
    end
  end

  assign timeout_err = to_q;
`else
  logic [31:0] unused_timeout_cyc;

  assign unused_timeout_cyc = TIMEOUT_CYC;
  assign wd_expire          = 1'b0;
  assign timeout_err        = 1'b0;
`endif

endmodule
